renkon_ctrl_linebuf_pad: RTL

- Sequences the padded line buffer across all input channels of one layer pass.
- Per channel: starts the line buffer, drives the image-memory read address in lock-step with the line buffer's input strobe, then waits for the window pipeline to drain.
- Tags output windows with first/last-channel flags for the downstream convolution accumulator.
- Sits between the layer controller (start/done) and the line buffer plus its source image memory.

---
 rtl/renkon_ctrl_linebuf_pad_pkg.sv | 19 +
 rtl/renkon_ctrl_chan_iter.sv | 54 +++++
 rtl/renkon_ctrl_linebuf_pad.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/renkon_ctrl_linebuf_pad_pkg.sv
// Shared types and constants for the padded line-buffer controller.
// Holds the controller state encoding plus the common bus widths.
// Imported by the controller top and its channel iterator.
package renkon_ctrl_linebuf_pad_pkg;

    localparam int LWIDTH        = 16;  // width of size / count configuration fields
    localparam int DWIDTH        = 16;  // pixel data width of the image memory
    localparam int DRAIN_LAT_DEF = 3;   // default line-buffer drain latency

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_FEED,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

endpackage

// File: rtl/renkon_ctrl_chan_iter.sv
// Channel iterator: counts input channels of one pass, flags first/last channel.
// Ports: clr_i restarts at channel 0 and latches n_chan_i; inc_i advances;
//        first_o/last_o are registered flags; tc_o is high while on the final channel.
module renkon_ctrl_chan_iter
    import renkon_ctrl_linebuf_pad_pkg::*;
#(
    parameter int CW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              inc_i,
    input  logic [LWIDTH-1:0] n_chan_i,
    output logic              first_o,
    output logic              last_o,
    output logic              tc_o
);

    logic [CW-1:0]     chan_q;
    logic [LWIDTH-1:0] n_q;
    logic              first_q;
    logic              last_q;
    logic [LWIDTH-1:0] chan_ext;
    logic [LWIDTH-1:0] chan_nxt_ext;
    logic [LWIDTH-1:0] last_idx;

    assign chan_ext     = LWIDTH'(chan_q);
    assign chan_nxt_ext = chan_ext + LWIDTH'(1);
    assign last_idx     = n_q - LWIDTH'(1);

    assign tc_o    = (chan_ext == last_idx);
    assign first_o = first_q;
    assign last_o  = last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chan_q  <= '0;
            n_q     <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (clr_i) begin
            chan_q  <= '0;
            n_q     <= n_chan_i;
            first_q <= 1'b1;
            // A single-channel pass is both first and last from the outset.
            last_q  <= (n_chan_i == LWIDTH'(1));
        end else if (inc_i) begin
            chan_q  <= chan_q + CW'(1);
            first_q <= 1'b0;
            last_q  <= (chan_nxt_ext == last_idx);
        end
    end

endmodule

// File: rtl/renkon_ctrl_linebuf_pad.sv
// Sequences the padded line buffer over every input channel of one layer pass.
// Ports: ctrl_* handshake with the layer controller; buf_* handshake with the line buffer;
//        img_addr feeds the 1-cycle image memory; out_valid/acc_* tag windows; err is sticky.
module renkon_ctrl_linebuf_pad
    import renkon_ctrl_linebuf_pad_pkg::*;
#(
    parameter int MAXFIL    = 5,
    parameter int MAXIMG    = 32,
    parameter int MAXCHAN   = 512,
    parameter int ADDRWIDTH = 16,
    parameter int DRAIN_LAT = DRAIN_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 ctrl_req,
    output logic                 ctrl_ack,
    output logic                 ctrl_done,
    input  logic [LWIDTH-1:0]    img_size,
    input  logic [LWIDTH-1:0]    fil_size,
    input  logic [LWIDTH-1:0]    pad_size,
    input  logic [LWIDTH-1:0]    n_chan,
    input  logic [ADDRWIDTH-1:0] img_offset,
    output logic                 buf_req,
    input  logic                 buf_ack,
    input  logic                 buf_ready,
    input  logic                 buf_valid,
    output logic [ADDRWIDTH-1:0] img_addr,
    output logic                 out_valid,
    output logic                 acc_first,
    output logic                 acc_last,
    output logic                 err
);

    localparam int CW  = $clog2(MAXCHAN) + 1;
    localparam int PW  = 2 * LWIDTH;
    localparam int DCW = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;

    state_t                state_q;
    logic [ADDRWIDTH-1:0]  offset_q;
    logic [ADDRWIDTH-1:0]  pix_q;      // pixels consumed since start, across channels
    logic [PW-1:0]         cpix_q;     // pixels consumed in the current channel
    logic [PW-1:0]         npix_q;     // img_size squared, fixed for the pass
    logic [DCW-1:0]        drain_q;
    logic                  seen_busy_q;
    logic                  err_q;

    logic start;
    logic chan_tc;
    logic chan_inc;

    assign start    = (state_q == S_IDLE) && ctrl_req;
    assign chan_inc = (state_q == S_NEXT) && !chan_tc;

    renkon_ctrl_chan_iter #(
        .CW (CW)
    ) u_chan_iter (
        .clk      (clk),
        .rst      (xrst),
        .clr_i    (start),
        .inc_i    (chan_inc),
        .n_chan_i (n_chan),
        .first_o  (acc_first),
        .last_o   (acc_last),
        .tc_o     (chan_tc)
    );

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q     <= S_IDLE;
            offset_q    <= '0;
            pix_q       <= '0;
            cpix_q      <= '0;
            npix_q      <= '0;
            drain_q     <= '0;
            seen_busy_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_req) begin
                        offset_q <= img_offset;
                        npix_q   <= PW'(img_size) * PW'(img_size);
                        pix_q    <= '0;
                        cpix_q   <= '0;
                        drain_q  <= '0;
                        err_q    <= 1'b0;
                        state_q  <= (n_chan == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    seen_busy_q <= 1'b0;
                    drain_q     <= '0;
                    state_q     <= S_FEED;
                end
                S_FEED: begin
                    if (buf_ready) begin
                        pix_q  <= pix_q + ADDRWIDTH'(1);
                        cpix_q <= cpix_q + PW'(1);
                    end
                    // The line buffer must first go busy, then return idle,
                    // so a stale idle ack right after the request is not taken as completion.
                    if (!buf_ack) begin
                        seen_busy_q <= 1'b1;
                    end else if (seen_busy_q) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DCW'(DRAIN_LAT - 1)) begin
                        drain_q <= '0;
                        state_q <= S_NEXT;
                    end else begin
                        drain_q <= drain_q + DCW'(1);
                    end
                end
                S_NEXT: begin
                    if (cpix_q != npix_q) begin
                        err_q <= 1'b1;
                    end
                    if (chan_tc) begin
                        state_q <= S_DONE;
                    end else begin
                        cpix_q  <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ctrl_ack  = (state_q == S_IDLE);
    assign ctrl_done = (state_q == S_DONE);
    assign buf_req   = (state_q == S_REQ);
    assign err       = err_q;

    // Lookahead by the current consume strobe so the synchronous memory
    // presents pixel p exactly when the line buffer samples it.
    assign img_addr  = offset_q + pix_q + ADDRWIDTH'(buf_ready);

    assign out_valid = buf_valid && ((state_q == S_FEED) || (state_q == S_DRAIN));

    // Configuration sanity at the moment a pass is accepted.
    a_cfg_range: assert property (@(posedge clk) disable iff (xrst)
        start |-> ((fil_size <= LWIDTH'(MAXFIL)) && (pad_size < fil_size) &&
                   (img_size <= LWIDTH'(MAXIMG)) && (n_chan <= LWIDTH'(MAXCHAN))));

endmodule
